// File: rtl/fp_pkg.sv
// FP32 field layout, subnormal detection and sequencer state encoding.
// Shared between the block sequencer and the downstream accumulator.
package fp_pkg;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_FRAC_MSB = 22;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    function automatic logic is_subnormal(input logic [31:0] w);
        return (w[FP_EXP_MSB:FP_EXP_LSB] == 8'd0) && (w[FP_FRAC_MSB:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_block_buf.sv
// DEPTH x 32 simple dual-port block buffer: synchronous write, registered read.
// Latency: one cycle from rd_en to rd_data; no backpressure, caller owns ordering.
module fp_block_buf #(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the accumulator's fp_input stage, so it resets.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fp_block_sequencer.sv
// Buffers a host block of FP32 words, then replays it gap-free to the accumulator.
// Latency: first write_en one cycle after the last accept; in_ready low during ISSUE/DONE.
module fp_block_sequencer
    import fp_pkg::*;
#(
    parameter int DEPTH        = 64,
    parameter bit FLUSH_DENORM = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        write_en,
    output logic [31:0] fp_input,
    output logic [7:0]  input_length,
    output logic        block_start,
    output logic        block_done,
    output logic        truncated,
    output logic        flushed
);

    localparam int       AW       = $clog2(DEPTH);
    localparam logic [7:0] DEPTH_M1 = 8'(DEPTH - 1);

    seq_state_t  state;
    logic [7:0]  wr_cnt;
    logic [7:0]  rd_ptr;
    logic        flush_acc;
    logic        accept;
    logic        wr_flush;
    logic [31:0] wr_word;

    assign in_ready = (state == LOAD);
    assign accept   = in_valid && in_ready;
    assign wr_flush = FLUSH_DENORM && is_subnormal(in_data);
    assign wr_word  = wr_flush ? {in_data[FP_SIGN_BIT], 31'b0} : in_data;

    fp_block_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (wr_word),
        .rd_en   (state == ISSUE),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (fp_input)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= LOAD;
            wr_cnt       <= '0;
            rd_ptr       <= '0;
            write_en     <= 1'b0;
            input_length <= '0;
            block_start  <= 1'b0;
            block_done   <= 1'b0;
            truncated    <= 1'b0;
            flushed      <= 1'b0;
            flush_acc    <= 1'b0;
        end else begin
            write_en    <= 1'b0;
            block_start <= 1'b0;
            block_done  <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        wr_cnt <= wr_cnt + 8'd1;
                        if (wr_flush) begin
                            flush_acc <= 1'b1;
                        end
                        if (in_last || wr_cnt == DEPTH_M1) begin
                            input_length <= wr_cnt + 8'd1;
                            truncated    <= !in_last;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // fp_input follows from the buffer's read register in the same edge.
                    write_en    <= 1'b1;
                    block_start <= (rd_ptr == 8'd0);
                    rd_ptr      <= rd_ptr + 8'd1;
                    if (rd_ptr == input_length - 8'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    block_done <= 1'b1;
                    flushed    <= flush_acc;
                    flush_acc  <= 1'b0;
                    wr_cnt     <= '0;
                    rd_ptr     <= '0;
                    state      <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule
